// File: rtl/apb_master_arbiter_pkg.sv
// Shared APB definitions: bus geometry record and the master sequencing states.
package apb_pkg;

    typedef struct packed {
        int unsigned ADDR_WIDTH;
        int unsigned DATA_WIDTH;
    } apb_parameter_t;

    localparam apb_parameter_t apb_parameter = '{ADDR_WIDTH: 32, DATA_WIDTH: 32};

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_master_state_e;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle; the master modport drives the request side and samples the slave response.
interface apb_interface
    import apb_pkg::*;
#(
    parameter apb_parameter_t PM = apb_parameter
) ();

    localparam int A = PM.ADDR_WIDTH;
    localparam int D = PM.DATA_WIDTH;

    logic [A-1:0]   paddr;
    logic           pprot;
    logic           psel;
    logic           penable;
    logic           pwrite;
    logic [D-1:0]   pwdata;
    logic [D/8-1:0] pstrb;
    logic           pready;
    logic [D-1:0]   prdata;
    logic           pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_master_arbiter_rr.sv
// Round-robin arbiter: search starts one past the last grant; pointer advances on each accepted grant.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] last_grant;
    int               cand;

    // Scan from the farthest offset down so the nearest requester after last_grant wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (req[cand]) begin
                grant     = '0;
                grant[cand] = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB bus among NUM_REQ requesters with round-robin arbitration.
// Optional ACCESS-phase watchdog: define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter apb_parameter_t PM = apb_parameter,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*PM.ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*PM.DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*PM.DATA_WIDTH/8-1:0] req_strb,
    input  logic [NUM_REQ-1:0]               req_prot,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [PM.DATA_WIDTH-1:0]         rsp_rdata,
    output logic                             rsp_slverr,
    apb_interface.master                     apb
);

    localparam int A     = PM.ADDR_WIDTH;
    localparam int D     = PM.DATA_WIDTH;
    localparam int S     = D / 8;
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_master_arbiter: parameter out of range");
    end

    apb_master_state_e state;
    logic [IDX_W-1:0]  owner;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              can_grant;
    logic              advance;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_valid),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A new grant is possible when idle, or in the completing ACCESS cycle for back-to-back transfers.
    always_comb begin
        can_grant = (state == APB_IDLE) || ((state == APB_ACCESS) && apb.pready);
        advance   = can_grant && (|req_valid);
        req_ready = can_grant ? grant : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= APB_IDLE;
            owner       <= '0;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.pprot   <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            apb.pstrb   <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            rsp_valid <= '0;

            if (advance) begin
                owner      <= grant_idx;
                apb.paddr  <= req_addr[int'(grant_idx)*A +: A];
                apb.pwrite <= req_write[grant_idx];
                apb.pwdata <= req_wdata[int'(grant_idx)*D +: D];
                apb.pstrb  <= req_strb[int'(grant_idx)*S +: S];
                apb.pprot  <= req_prot[grant_idx];
`ifdef APB_ARB_TIMEOUT_EN
                tmo_cnt    <= '0;
`endif
            end

            case (state)
                APB_IDLE: begin
                    if (advance) begin
                        state    <= APB_SETUP;
                        apb.psel <= 1'b1;
                    end
                end
                APB_SETUP: begin
                    state       <= APB_ACCESS;
                    apb.penable <= 1'b1;
                end
                APB_ACCESS: begin
                    if (apb.pready) begin
                        rsp_valid   <= NUM_REQ'(1) << owner;
                        rsp_rdata   <= apb.pwrite ? '0 : apb.prdata;
                        rsp_slverr  <= apb.pslverr;
                        apb.penable <= 1'b0;
                        if (advance) begin
                            state <= APB_SETUP;
                        end else begin
                            state    <= APB_IDLE;
                            apb.psel <= 1'b0;
                        end
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    // Stuck slave: abandon the transfer and report it as an error.
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid   <= NUM_REQ'(1) << owner;
                        rsp_rdata   <= '0;
                        rsp_slverr  <= 1'b1;
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        state       <= APB_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= APB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized scoreboard bench for apb_master_arbiter with a transaction-level reference model.
`timescale 1ns/1ps
module tb_apb_master_arbiter;
    import apb_pkg::*;

    localparam int N = 4;
    localparam int A = 32;
    localparam int D = 32;
    localparam int S = D / 8;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int TMO    = 8;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 256;
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        int           idx;
        logic [A-1:0] addr;
        logic         wr;
        logic [D-1:0] wdata;
        logic [S-1:0] strb;
        logic         prot;
        logic [D-1:0] prdata;
        logic         err;
        int           waits;
    } xfer_t;

    typedef struct {
        int           idx;
        logic [D-1:0] rdata;
        logic         err;
        int           cyc;
    } rsp_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid, req_ready, req_write, req_prot, rsp_valid;
    logic [N*A-1:0] req_addr;
    logic [N*D-1:0] req_wdata;
    logic [N*S-1:0] req_strb;
    logic [D-1:0]   rsp_rdata;
    logic           rsp_slverr;

    apb_interface #(.PM(apb_parameter)) apb ();

    apb_master_arbiter #(
        .PM             (apb_parameter),
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .req_strb   (req_strb),
        .req_prot   (req_prot),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .apb        (apb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    xfer_t apb_q[$];
    rsp_t  rsp_q[$];
    int    grant_log[$];
    int    grant_cyc[$];

    int          m_last = N - 1;
    int          m_ok   = 0;
    int          ntx    = 0;
    bit          long_next = 1'b0;
    int          drv_mode  = 0;
    logic [N-1:0] acc = '0;
    bit          first_cmd [N] = '{default: 1'b1};

    xfer_t        cur;
    int           wleft = 0;
    bit           was_setup = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic new_cmd(input int i);
        logic [A-1:0] a;
        logic         w;
        logic [D-1:0] wd;
        logic [S-1:0] st;
        a  = A'($urandom) & ~A'(3);
        w  = 1'($urandom_range(0, 1));
        wd = D'($urandom);
        st = S'($urandom_range(0, 15));
        if (first_cmd[i]) begin
            first_cmd[i] = 1'b0;
            if (i == 0) begin
                a = 32'h10; w = 1'b1; wd = 32'hA5A5A5A5; st = 4'hF;
            end else if (i == 1) begin
                a = 32'h20; w = 1'b0;
            end
        end
        req_addr[i*A +: A]  = a;
        req_write[i]        = w;
        req_wdata[i*D +: D] = wd;
        req_strb[i*S +: S]  = st;
        req_prot[i]         = 1'($urandom_range(0, 1));
    endtask

    always @(posedge clk) cyc++;

    // Requester drivers: hold a command until accepted; mode 2 may also withdraw it.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (drv_mode == 0) begin
                req_valid[i] = 1'b0;
            end else if (req_valid[i] && !acc[i]) begin
                if (drv_mode == 2 && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end else if (drv_mode == 1 || (drv_mode == 2 && $urandom_range(0, 2) == 0)) begin
                new_cmd(i);
                req_valid[i] = 1'b1;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // Response monitor, APB slave responder and arbitration reference model.
    rsp_t         r, rr;
    xfer_t        x;
    logic [N-1:0] oh, exp_rdy;
    int           win;

    always @(negedge clk) begin
        if (!reset_n) begin
            acc        = '0;
            was_setup  = 1'b0;
            apb.pready = 1'b0;
        end else begin
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    r = rsp_q.pop_front();
                    oh = '0;
                    oh[r.idx] = 1'b1;
                    chk("rsp_valid", 64'(rsp_valid), 64'(oh));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
                    chk("rsp_slverr", 64'(rsp_slverr), 64'(r.err));
                    chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
                end
            end else if (rsp_q.size() != 0 && rsp_q[0].cyc < cyc) begin
                chk("rsp_missing_at_cycle", 64'(cyc), 64'(rsp_q[0].cyc));
                void'(rsp_q.pop_front());
            end

            if (was_setup) chk("access_after_setup", 64'({apb.psel, apb.penable}), 64'd3);
            was_setup = apb.psel && !apb.penable;

            if (apb.psel && !apb.penable) begin
                if (apb_q.size() == 0) begin
                    chk("setup_unexpected", 64'(apb.psel), 64'd0);
                end else begin
                    cur   = apb_q.pop_front();
                    wleft = cur.waits;
                    chk("setup_paddr", 64'(apb.paddr), 64'(cur.addr));
                    chk("setup_pwrite", 64'(apb.pwrite), 64'(cur.wr));
                    chk("setup_pwdata", 64'(apb.pwdata), 64'(cur.wdata));
                    chk("setup_pstrb", 64'(apb.pstrb), 64'(cur.strb));
                    chk("setup_pprot", 64'(apb.pprot), 64'(cur.prot));
                end
                apb.pready = 1'b0;
            end else if (apb.psel && apb.penable) begin
                chk("access_paddr", 64'(apb.paddr), 64'(cur.addr));
                chk("access_pwrite", 64'(apb.pwrite), 64'(cur.wr));
                chk("access_pwdata", 64'(apb.pwdata), 64'(cur.wdata));
                apb.pready  = (wleft == 0);
                apb.prdata  = cur.prdata;
                apb.pslverr = cur.err;
                if (wleft > 0) wleft--;
            end else begin
                apb.pready  = 1'b0;
                apb.prdata  = D'($urandom);
                apb.pslverr = 1'($urandom_range(0, 1));
            end

            #1;
            exp_rdy = '0;
            if (cyc >= m_ok) begin
                win = -1;
                for (int k = 1; k <= N; k++)
                    if (win < 0 && req_valid[(m_last + k) % N]) win = (m_last + k) % N;
                if (win >= 0) begin
                    x.idx    = win;
                    x.addr   = req_addr[win*A +: A];
                    x.wr     = req_write[win];
                    x.wdata  = req_wdata[win*D +: D];
                    x.strb   = req_strb[win*S +: S];
                    x.prot   = req_prot[win];
                    x.prdata = D'($urandom);
                    x.err    = ($urandom_range(0, 7) == 0);
                    x.waits  = $urandom_range(0, 3);
                    if (TMO_EN && $urandom_range(0, 9) == 0) x.waits = TMO + 2;
                    if (ntx == 0) begin
                        x.waits = 0; x.err = 1'b0;
                    end else if (ntx == 1) begin
                        x.waits = 3; x.prdata = 32'h12345678; x.err = 1'b0;
                    end else if (ntx == 2) begin
                        x.waits = 0; x.err = 1'b1;
                    end else if (ntx == 3) begin
                        x.waits = TMO_EN ? TMO + 5 : 1; x.err = 1'b0;
                    end
                    if (long_next) begin
                        x.waits   = 1000;
                        long_next = 1'b0;
                    end
                    apb_q.push_back(x);
                    rr.idx = win;
                    if (TMO_EN && x.waits >= TMO) begin
                        rr.cyc   = cyc + 2 + TMO;
                        rr.rdata = '0;
                        rr.err   = 1'b1;
                        m_ok     = cyc + 2 + TMO;
                    end else begin
                        rr.cyc   = cyc + 3 + x.waits;
                        rr.rdata = x.wr ? '0 : x.prdata;
                        rr.err   = x.err;
                        m_ok     = cyc + 2 + x.waits;
                    end
                    rsp_q.push_back(rr);
                    exp_rdy[win] = 1'b1;
                    m_last = win;
                    ntx++;
                end
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            acc = req_ready;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    int exp_order [5] = '{0, 1, 2, 3, 0};
    bit found;

    initial begin
        reset_n     = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_write   = '0;
        req_wdata   = '0;
        req_strb    = '0;
        req_prot    = '0;
        apb.pready  = 1'b0;
        apb.prdata  = '0;
        apb.pslverr = 1'b0;
        drv_mode    = 1;

        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        chk("reset_psel", 64'(apb.psel), 64'd0);
        chk("reset_penable", 64'(apb.penable), 64'd0);
        chk("reset_pwrite", 64'(apb.pwrite), 64'd0);
        chk("reset_pprot", 64'(apb.pprot), 64'd0);
        chk("reset_paddr", 64'(apb.paddr), 64'd0);
        chk("reset_pwdata", 64'(apb.pwdata), 64'd0);
        chk("reset_pstrb", 64'(apb.pstrb), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset_rsp_slverr", 64'(rsp_slverr), 64'd0);

        // Contention from reset: all requesters valid.
        @(posedge clk); #1;
        m_ok    = cyc;
        reset_n = 1'b1;
        for (int t = 0; t < 200 && ntx < 5; t++) @(posedge clk);
        if (ntx < 5) chk("contention_grants_seen", 64'(ntx), 64'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk($sformatf("grant_order_%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
        if (grant_cyc.size() >= 2)
            chk("back_to_back_gap", 64'(grant_cyc[1] - grant_cyc[0]), 64'd2);

        // Randomized traffic.
        drv_mode = 2;
        repeat (600) @(posedge clk);

        // Reset while a transfer is stalled in ACCESS.
        long_next = 1'b1;
        found     = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk); #2;
            if (apb.psel && apb.penable && cur.waits == 1000) found = 1'b1;
        end
        if (!found) chk("stalled_access_reached", 64'(found), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_psel", 64'(apb.psel), 64'd0);
        chk("async_reset_penable", 64'(apb.penable), 64'd0);
        apb_q.delete();
        rsp_q.delete();
        grant_log.delete();
        m_last   = N - 1;
        drv_mode = 1;
        repeat (3) begin
            @(negedge clk); #2;
            chk("rsp_during_reset", 64'(rsp_valid), 64'd0);
            chk("psel_during_reset", 64'(apb.psel), 64'd0);
        end
        @(posedge clk); #1;
        m_ok    = cyc;
        reset_n = 1'b1;
        for (int t = 0; t < 50 && grant_log.size() == 0; t++) @(posedge clk);
        if (grant_log.size() == 0) chk("grant_after_reset_seen", 64'd0, 64'd1);
        else chk("first_grant_after_reset", 64'(grant_log[0]), 64'd0);

        drv_mode = 2;
        repeat (200) @(posedge clk);

        // Drain outstanding work.
        drv_mode = 3;
        found    = 1'b0;
        for (int t = 0; t < 400 && !found; t++) begin
            @(negedge clk); #3;
            if (rsp_q.size() == 0 && req_valid == '0 && !apb.psel) found = 1'b1;
        end
        if (!found) chk("drain_outstanding", 64'(rsp_q.size()), 64'd0);
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
